// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern transmitter, PATTERN MSB-first, repeated with filler gaps
module seq_pattern_gen #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4,
    parameter logic             GAP_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_reps_left;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;

    // r_reps_left counts the repetition in flight, so it never has to reach 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_reps_left <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_reps_left <= rep_count;
                        r_gap       <= gap_len;
                        busy        <= 1'b1;
                        if (rep_count == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_SHIFT;
                            r_idx     <= IDX_TOP;
                            out       <= PATTERN[PAT_W-1];
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                        out   <= PATTERN[r_idx - 1'b1];
                    end else if (r_reps_left > CNT_W'(1)) begin
                        r_reps_left <= r_reps_left - 1'b1;
                        if (r_gap != '0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= r_gap - 1'b1;
                            out       <= GAP_BIT;
                        end else begin
                            r_idx <= IDX_TOP;
                            out   <= PATTERN[PAT_W-1];
                        end
                    end else begin
                        r_state     <= S_DONE;
                        r_reps_left <= '0;
                        out         <= 1'b0;
                        out_valid   <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_SHIFT;
                        r_idx   <= IDX_TOP;
                        out     <= PATTERN[PAT_W-1];
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
